// File: rtl/ula_pkg.sv
// Shared definitions for the ULA and the sequential multiplier.
// Holds the ULA control codes and the multiplier FSM state type.
package ula_pkg;

    // ULA control codes
    localparam logic [4:0] ULA_SOMA     = 5'b00000;
    localparam logic [4:0] ULA_SUBTRAI  = 5'b00001;
    localparam logic [4:0] ULA_E        = 5'b00010;
    localparam logic [4:0] ULA_OU       = 5'b00011;
    localparam logic [4:0] ULA_XOU      = 5'b00100;
    localparam logic [4:0] ULA_DESL_ESQ = 5'b01000;
    localparam logic [4:0] ULA_DESL_DIR = 5'b01001;
    localparam logic [4:0] ULA_ZERO     = 5'b10000;
    localparam logic [4:0] ULA_PASSA_A  = 5'b10101;

    // Multiplier FSM states
    typedef enum logic [1:0] {
        OCIOSO,
        SOMA,
        DESLOCA,
        FIM
    } estado_t;

    // True while an operation is in flight (everything except idle).
    function automatic logic estado_ocupado(estado_t e);
        return e != OCIOSO;
    endfunction

endpackage

// File: rtl/ula.sv
// ULA: purely combinational arithmetic/logic unit.
// Ports:
//   operandoA, operandoB : LARGURA-bit operands
//   controle             : 5-bit operation select (codes in ula_pkg)
//   resultadoOp          : LARGURA-bit result, unknown codes yield zero
module ula
    import ula_pkg::*;
#(
    parameter int unsigned LARGURA = 16
) (
    input  logic [LARGURA-1:0] operandoA,
    input  logic [LARGURA-1:0] operandoB,
    input  logic [4:0]         controle,
    output logic [LARGURA-1:0] resultadoOp
);

    always_comb begin
        resultadoOp = '0;
        case (controle)
            ULA_SOMA:     resultadoOp = operandoA + operandoB;
            ULA_SUBTRAI:  resultadoOp = operandoA - operandoB;
            ULA_E:        resultadoOp = operandoA & operandoB;
            ULA_OU:       resultadoOp = operandoA | operandoB;
            ULA_XOU:      resultadoOp = operandoA ^ operandoB;
            ULA_DESL_ESQ: resultadoOp = operandoA << operandoB;
            ULA_DESL_DIR: resultadoOp = operandoA >> operandoB;
            ULA_PASSA_A:  resultadoOp = operandoA;
            default:      resultadoOp = '0;
        endcase
    end

endmodule

// File: rtl/ula_mult_seq.sv
// ula_mult_seq: shift-and-add multiplier that borrows an external ULA for
// every add and shift. Produces the low LARGURA bits of entA*entB with a
// fixed latency of 2*LARGURA+1 cycles after inicio is accepted.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   inicio, cancela   : start pulse (idle only), abort (SOMA/DESLOCA only)
//   entA, entB        : multiplicand / multiplier, captured with inicio
//   ocupado, pronto   : busy flag, one-cycle result-valid pulse
//   produto           : registered result, held until the next one
//   ula_operandoA/B, ula_controle : drive the ULA
//   ula_resultado     : ULA result, combinational from the three above
module ula_mult_seq
    import ula_pkg::*;
#(
    parameter int unsigned LARGURA = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inicio,
    input  logic               cancela,
    input  logic [LARGURA-1:0] entA,
    input  logic [LARGURA-1:0] entB,
    output logic               ocupado,
    output logic               pronto,
    output logic [LARGURA-1:0] produto,
    output logic [LARGURA-1:0] ula_operandoA,
    output logic [LARGURA-1:0] ula_operandoB,
    output logic [4:0]         ula_controle,
    input  logic [LARGURA-1:0] ula_resultado
);

    localparam int unsigned CNT_W = $clog2(LARGURA);
    localparam logic [CNT_W-1:0] CNT_ULTIMO = CNT_W'(LARGURA - 1);

    estado_t            estado_q, estado_d;
    logic [LARGURA-1:0] acc_q, acc_d;
    logic [LARGURA-1:0] mcand_q, mcand_d;
    logic [LARGURA-1:0] mult_q, mult_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LARGURA-1:0] produto_q, produto_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q  <= OCIOSO;
            acc_q     <= '0;
            mcand_q   <= '0;
            mult_q    <= '0;
            cnt_q     <= '0;
            produto_q <= '0;
        end else begin
            estado_q  <= estado_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mult_q    <= mult_d;
            cnt_q     <= cnt_d;
            produto_q <= produto_d;
        end
    end

    // Next state and datapath updates
    always_comb begin
        estado_d  = estado_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mult_d    = mult_q;
        cnt_d     = cnt_q;
        produto_d = produto_q;
        case (estado_q)
            OCIOSO: begin
                if (inicio) begin
                    acc_d    = '0;
                    mcand_d  = entA;
                    mult_d   = entB;
                    cnt_d    = '0;
                    estado_d = SOMA;
                end
            end
            SOMA: begin
                if (cancela) begin
                    estado_d = OCIOSO;
                end else begin
                    acc_d    = ula_resultado;
                    estado_d = DESLOCA;
                end
            end
            DESLOCA: begin
                if (cancela) begin
                    estado_d = OCIOSO;
                end else begin
                    mcand_d = ula_resultado;
                    mult_d  = mult_q >> 1;
                    if (cnt_q == CNT_ULTIMO) begin
                        // acc already holds the sum from the last SOMA
                        produto_d = acc_q;
                        estado_d  = FIM;
                    end else begin
                        cnt_d    = cnt_q + 1'b1;
                        estado_d = SOMA;
                    end
                end
            end
            FIM:     estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase
    end

    // Outputs and ULA command decode
    always_comb begin
        ula_controle  = ULA_ZERO;
        ula_operandoA = '0;
        ula_operandoB = '0;
        case (estado_q)
            SOMA: begin
                ula_operandoA = acc_q;
                if (mult_q[0]) begin
                    ula_controle  = ULA_SOMA;
                    ula_operandoB = mcand_q;
                end else begin
                    ula_controle = ULA_PASSA_A;
                end
            end
            DESLOCA: begin
                ula_controle  = ULA_DESL_ESQ;
                ula_operandoA = mcand_q;
                ula_operandoB = LARGURA'(1);
            end
            default: begin
                ula_controle  = ULA_ZERO;
                ula_operandoA = '0;
                ula_operandoB = '0;
            end
        endcase
    end

    assign ocupado = estado_ocupado(estado_q);
    assign pronto  = (estado_q == FIM);
    assign produto = produto_q;

endmodule

// File: tb/tb_ula_mult_seq.sv
// Bench for ula_mult_seq wired to the ULA. A cycle-level model describes
// each operation by its offset k since acceptance (1..2W+1) and derives
// every expected output from plain multiplication of the captured operands.
module tb_ula_mult_seq;

    localparam int W   = 16;
    localparam int LAT = 2 * W + 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         inicio, cancela;
    logic [W-1:0] entA, entB;
    logic         ocupado, pronto;
    logic [W-1:0] produto, op_a, op_b, resultado;
    logic [4:0]   controle;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ula_mult_seq #(.LARGURA(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .inicio        (inicio),
        .cancela       (cancela),
        .entA          (entA),
        .entB          (entB),
        .ocupado       (ocupado),
        .pronto        (pronto),
        .produto       (produto),
        .ula_operandoA (op_a),
        .ula_operandoB (op_b),
        .ula_controle  (controle),
        .ula_resultado (resultado)
    );

    ula #(.LARGURA(W)) u_ula (
        .operandoA   (op_a),
        .operandoB   (op_b),
        .controle    (controle),
        .resultadoOp (resultado)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [W-1:0] lo_mul(logic [W-1:0] x, logic [W-1:0] y);
        return x * y;
    endfunction

    function automatic logic [W-1:0] shl(logic [W-1:0] x, int n);
        return x << n;
    endfunction

    function automatic logic [W-1:0] low_mask(int n);
        logic [W-1:0] one;
        one = 1;
        return (one << n) - 1'b1;
    endfunction

    // Reference model
    logic         m_act;
    int           m_k;
    logic [W-1:0] m_a, m_b, m_prod;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act  <= 1'b0;
            m_k    <= 0;
            m_a    <= '0;
            m_b    <= '0;
            m_prod <= '0;
        end else if (!m_act) begin
            if (inicio) begin
                m_act <= 1'b1;
                m_k   <= 1;
                m_a   <= entA;
                m_b   <= entB;
            end
        end else if (m_k == LAT) begin
            m_act <= 1'b0;
        end else if (cancela) begin
            m_act <= 1'b0;
        end else begin
            m_k <= m_k + 1;
            if (m_k == LAT - 1) m_prod <= lo_mul(m_a, m_b);
        end
    end

    // Compare process: odd k adds bit (k-1)/2, even k shifts the multiplicand
    always @(negedge clk) begin
        chk("ocupado", ocupado, m_act);
        chk("pronto", pronto, m_act && m_k == LAT);
        chk("produto", produto, m_prod);
        if (!m_act || m_k == LAT) begin
            chk("ctl_idle", controle, 5'b10000);
            chk("opA_idle", op_a, 0);
            chk("opB_idle", op_b, 0);
        end else if (m_k % 2 == 1) begin
            chk("opA_soma", op_a, lo_mul(m_a, m_b & low_mask((m_k - 1) / 2)));
            if (m_b[(m_k - 1) / 2]) begin
                chk("ctl_soma", controle, 5'b00000);
                chk("opB_soma", op_b, shl(m_a, (m_k - 1) / 2));
            end else begin
                chk("ctl_passa", controle, 5'b10101);
            end
        end else begin
            chk("ctl_desl", controle, 5'b01000);
            chk("opA_desl", op_a, shl(m_a, m_k / 2 - 1));
            chk("opB_desl", op_b, 1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 1 of the new operation.
    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
        step();
        entA   = a;
        entB   = b;
        inicio = 1'b1;
        step();
        inicio = 1'b0;
    endtask

    task automatic wait_pronto(output int lat, output int npassa);
        lat    = -1;
        npassa = 0;
        for (int c = 1; c <= LAT + 8; c++) begin
            @(negedge clk);
            if (controle == 5'b10101) npassa++;
            if (pronto) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp, input int exp_passa);
        int lat, np;
        start(a, b);
        wait_pronto(lat, np);
        chk("latency", lat, LAT);
        chk("produto_lit", produto, exp);
        if (exp_passa >= 0) chk("passa_count", np, exp_passa);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 16'h8000;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int np;
        rst_n   = 1'b1;
        inicio  = 1'b0;
        cancela = 1'b0;
        entA    = '0;
        entB    = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ocupado", ocupado, 0);
        chk("rst_pronto", pronto, 0);
        chk("rst_produto", produto, 0);
        chk("rst_ctl", controle, 5'b10000);
        step();
        rst_n = 1'b1;

        run_op(16'd3, 16'd5, 16'd15, 14);
        run_op(16'hFFFF, 16'hFFFF, 16'h0001, 0);
        run_op(16'h8000, 16'd2, 16'h0000, 15);
        run_op(16'd5, 16'd0, 16'h0000, 16);
        run_op(16'd0, 16'hABCD, 16'h0000, -1);
        run_op(16'd3, 16'd5, 16'd15, -1);

        // Abort during cycle 10: idle next cycle, no pronto, produto kept
        start(16'd9, 16'd11);
        repeat (9) step();
        cancela = 1'b1;
        step();
        cancela = 1'b0;
        @(negedge clk);
        chk("cancel_ocupado", ocupado, 0);
        chk("cancel_produto", produto, 15);
        np = 0;
        repeat (LAT + 4) begin
            @(negedge clk);
            if (pronto) np++;
        end
        chk("cancel_no_pronto", np, 0);

        // inicio in cycles 5 and 33 must be ignored
        start(16'd5, 16'd6);
        repeat (4) step();
        inicio = 1'b1;
        entA   = 16'd7;
        step();
        inicio = 1'b0;
        repeat (27) step();
        inicio = 1'b1;
        @(negedge clk);
        chk("ign_pronto", pronto, 1);
        chk("ign_produto", produto, 30);
        step();
        inicio = 1'b0;
        @(negedge clk);
        chk("ign_idle", ocupado, 0);
        run_op(16'd7, 16'd3, 16'd21, -1);

        // Asynchronous reset in cycle 20
        start(16'h1234, 16'h0056);
        repeat (19) step();
        rst_n = 1'b0;
        #1;
        chk("arst_ocupado", ocupado, 0);
        chk("arst_pronto", pronto, 0);
        chk("arst_produto", produto, 0);
        chk("arst_ctl", controle, 5'b10000);
        chk("arst_opA", op_a, 0);
        step();
        rst_n = 1'b1;
        run_op(16'd3, 16'd5, 16'd15, 14);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            step();
            inicio  = ($urandom_range(0, 3) == 0);
            cancela = ($urandom_range(0, 63) == 0);
            entA    = pick();
            entB    = pick();
        end
        step();
        inicio  = 1'b0;
        cancela = 1'b0;
        repeat (LAT + 2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
